// File: rtl/riscv_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit_if
// Instruction-memory request/response bundle between the IF stage and imem.
//   o_fetch_imem_req        fetch -> imem  request valid
//   o_fetch_imem_addr       fetch -> imem  word-aligned request address
//   i_fetch_imem_ready      imem  -> fetch request accepted when req & ready
//   i_fetch_imem_rsp_valid  imem  -> fetch in-order response valid (no backpressure)
//   i_fetch_imem_rsp_data   imem  -> fetch instruction word
// Signal names keep the fetch unit's point of view (o_ = driven by fetch).
// ---------------------------------------------------------------------------
interface riscv_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            o_fetch_imem_req;
    logic [XLEN-1:0] o_fetch_imem_addr;
    logic            i_fetch_imem_ready;
    logic            i_fetch_imem_rsp_valid;
    logic [XLEN-1:0] i_fetch_imem_rsp_data;

    modport master (
        output o_fetch_imem_req,
        output o_fetch_imem_addr,
        input  i_fetch_imem_ready,
        input  i_fetch_imem_rsp_valid,
        input  i_fetch_imem_rsp_data
    );

    modport slave (
        input  o_fetch_imem_req,
        input  o_fetch_imem_addr,
        output i_fetch_imem_ready,
        output i_fetch_imem_rsp_valid,
        output i_fetch_imem_rsp_data
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit
// IF stage of the RV32I pipeline. Issues in-order imem requests, keeps a
// DEPTH-entry {pc,instr} prefetch queue, allows up to DEPTH requests in
// flight and squashes in-flight responses after a redirect.
//
// Parameters: XLEN (data/address width), DEPTH (queue entries and max
// outstanding, power of two >= 2), RESET_PC (first fetch address).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   imem                    imem request/response bundle (master side)
//   o_fetch_valid/pc/instr  instruction presented to ID
//   i_fetch_ready           ID consumes on valid & ready
//   i_fetch_redirect(_pc)   redirect/flush strobe and new target from EX
//
// Build option: RISCV_FETCH_BYPASS_EN -- when the queue is empty and ID is
// ready, a good response goes straight to o_fetch_* in the same cycle.
// Without it every response passes through the queue (1-cycle latency).
// ---------------------------------------------------------------------------
module riscv_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    riscv_fetch_unit_if.master    imem,
    output logic                  o_fetch_valid,
    output logic [XLEN-1:0]       o_fetch_pc,
    output logic [XLEN-1:0]       o_fetch_instr,
    input  logic                  i_fetch_ready,
    input  logic                  i_fetch_redirect,
    input  logic [XLEN-1:0]       i_fetch_redirect_pc
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] last_pc_q, last_instr_q;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];

    logic [CW:0]     occ;
    logic            req, req_fire, rsp_fire, rsp_keep;
    logic            head_valid, bypass, push, pop;
    logic [XLEN-1:0] redir_pc;

    always_comb begin
        // Queue slots are reserved when a request is issued, so occupancy
        // counts both queued entries and requests still in flight.
        occ        = {1'b0, count_q} + {1'b0, outstanding_q};
        req        = ~i_rst & ~i_fetch_redirect & (occ < DEPTH_W);
        req_fire   = req & imem.i_fetch_imem_ready;
        rsp_fire   = ~i_rst & imem.i_fetch_imem_rsp_valid & (outstanding_q != '0);
        rsp_keep   = rsp_fire & (discard_q == '0) & ~i_fetch_redirect;
        head_valid = (count_q != '0);
`ifdef RISCV_FETCH_BYPASS_EN
        bypass     = rsp_keep & ~head_valid & i_fetch_ready;
`else
        bypass     = 1'b0;
`endif
        push       = rsp_keep & ~bypass;
        redir_pc   = i_fetch_redirect_pc & ~XLEN'(3);

        imem.o_fetch_imem_req  = req;
        imem.o_fetch_imem_addr = req_pc_q;

        o_fetch_valid = ~i_rst & ~i_fetch_redirect & (head_valid | bypass);
        pop           = head_valid & o_fetch_valid & i_fetch_ready;

        if (i_rst) begin
            o_fetch_pc    = '0;
            o_fetch_instr = '0;
        end else if (head_valid) begin
            o_fetch_pc    = q_pc[rd_ptr_q];
            o_fetch_instr = q_instr[rd_ptr_q];
        end else if (bypass) begin
            o_fetch_pc    = rsp_pc_q;
            o_fetch_instr = imem.i_fetch_imem_rsp_data;
        end else begin
            o_fetch_pc    = last_pc_q;
            o_fetch_instr = last_instr_q;
        end

        req_pc_d      = req_fire ? req_pc_q + STEP : req_pc_q;
        rsp_pc_d      = rsp_keep ? rsp_pc_q + STEP : rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        discard_d     = discard_q - CW'(rsp_fire & (discard_q != '0));
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);

        // Everything still in flight after this cycle's response belongs to
        // the old path; recomputing (not adding) avoids double counting.
        if (i_fetch_redirect) begin
            req_pc_d  = redir_pc;
            rsp_pc_d  = redir_pc;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            discard_d = outstanding_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_pc_q     <= '0;
            last_instr_q  <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            last_pc_q     <= o_fetch_pc;
            last_instr_q  <= o_fetch_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= rsp_pc_q;
            q_instr[wr_ptr_q] <= imem.i_fetch_imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;
`ifdef RISCV_FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, fready, redir;
    logic [31:0] redir_pc;
    logic        valid;
    logic [31:0] fpc, finstr;

    always #5 clk = ~clk;

    riscv_fetch_unit_if #(.XLEN(XLEN)) imem_if ();

    riscv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .imem                (imem_if.master),
        .o_fetch_valid       (valid),
        .o_fetch_pc          (fpc),
        .o_fetch_instr       (finstr),
        .i_fetch_ready       (fready),
        .i_fetch_redirect    (redir),
        .i_fetch_redirect_pc (redir_pc)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];

    typedef struct {
        logic rst, rdy, rdr; logic [31:0] rpc;
        logic e_req, ca; logic [31:0] e_addr;
        logic e_valid, cp; logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[14];

    int          cyc, lat, checks, errors, consumed;
    logic        sb_en;
    logic [31:0] exp_pc;
    logic        s_req, s_valid, s_rsp;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t v(input logic r, input logic rd, input logic rx, input logic [31:0] rp,
                               input logic er, input logic ca, input logic [31:0] ea,
                               input logic ev, input logic cp, input logic [31:0] ep);
        vec_t t;
        t.rst = r; t.rdy = rd; t.rdr = rx; t.rpc = rp;
        t.e_req = er; t.ca = ca; t.e_addr = ea;
        t.e_valid = ev; t.cp = cp; t.e_pc = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: imem model drives its response, outputs are sampled 1ns
    // later, then time advances to the next falling edge.
    task automatic cycle();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_if.i_fetch_imem_rsp_valid = 1'b1;
            imem_if.i_fetch_imem_rsp_data  = memf(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_if.i_fetch_imem_rsp_valid = 1'b0;
            imem_if.i_fetch_imem_rsp_data  = 32'h0;
        end
        #1;
        s_req   = imem_if.o_fetch_imem_req;
        s_addr  = imem_if.o_fetch_imem_addr;
        s_rsp   = imem_if.i_fetch_imem_rsp_valid;
        s_valid = valid;
        s_pc    = fpc;
        s_instr = finstr;
        if (s_req && imem_if.i_fetch_imem_ready) pend.push_back('{addr: s_addr, due: cyc + lat});
        if (s_valid && fready) begin
            consumed++;
            if (sb_en) begin
                chk("sb_pc", s_pc, exp_pc);
                chk("sb_instr", s_instr, memf(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; redir = 1'b0;
        cycle();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_req", 32'(s_req), 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (pend.size() == 0) break;
            cycle();
        end
        rst = 1'b0;
        exp_pc = RPC;
    endtask

    task automatic wait_consume(input string name, input logic [31:0] exp);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_valid && fready) begin
                chk(name, s_pc, exp);
                return;
            end
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rsp, t_val, acc, c0;
        logic found;
        checks = 0; errors = 0; consumed = 0; cyc = 0; lat = 1;
        sb_en = 1'b0; exp_pc = RPC;
        rst = 1'b1; fready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        imem_if.i_fetch_imem_ready     = 1'b1;
        imem_if.i_fetch_imem_rsp_valid = 1'b0;
        imem_if.i_fetch_imem_rsp_data  = 32'h0;

        // rst rdy rdr rpc | req chkaddr addr | valid chkpc pc
        tbl[0]  = v(1'b1,1'b1,1'b0,32'h0,   1'b0,1'b0,32'h0,   1'b0,1'b1,32'h0);
        tbl[1]  = v(1'b1,1'b1,1'b0,32'h0,   1'b0,1'b1,32'h100, 1'b0,1'b1,32'h0);
        tbl[2]  = v(1'b0,1'b1,1'b0,32'h0,   1'b1,1'b1,32'h100, 1'b0,1'b1,32'h0);
        tbl[3]  = v(1'b0,1'b1,1'b0,32'h0,   1'b1,1'b1,32'h104, 1'b0,1'b1,32'h0);
        tbl[4]  = v(1'b0,1'b1,1'b0,32'h0,   1'b1,1'b1,32'h108, 1'b1,1'b1,32'h100);
        tbl[5]  = v(1'b0,1'b1,1'b0,32'h0,   1'b1,1'b1,32'h10C, 1'b1,1'b1,32'h104);
        tbl[6]  = v(1'b0,1'b1,1'b0,32'h0,   1'b1,1'b1,32'h110, 1'b1,1'b1,32'h108);
        tbl[7]  = v(1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'h114, 1'b1,1'b1,32'h10C);
        tbl[8]  = v(1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'h118, 1'b1,1'b1,32'h10C);
        tbl[9]  = v(1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'h10C);
        tbl[10] = v(1'b0,1'b0,1'b1,32'h203, 1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0);
        tbl[11] = v(1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'h200, 1'b0,1'b1,32'h10C);
        tbl[12] = v(1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'h204, 1'b0,1'b1,32'h10C);
        tbl[13] = v(1'b0,1'b1,1'b0,32'h0,   1'b1,1'b1,32'h208, 1'b1,1'b1,32'h200);

        // Startup, stall, hold-last-value and misaligned redirect, cycle by cycle.
        if (BYP == 0) begin
            for (int k = 0; k < 14; k++) begin
                rst = tbl[k].rst; fready = tbl[k].rdy;
                redir = tbl[k].rdr; redir_pc = tbl[k].rpc;
                cycle();
                chk($sformatf("tbl%0d_req", k), 32'(s_req), 32'(tbl[k].e_req));
                chk($sformatf("tbl%0d_valid", k), 32'(s_valid), 32'(tbl[k].e_valid));
                if (tbl[k].ca) chk($sformatf("tbl%0d_addr", k), s_addr, tbl[k].e_addr);
                if (tbl[k].cp) begin
                    chk($sformatf("tbl%0d_pc", k), s_pc, tbl[k].e_pc);
                    chk($sformatf("tbl%0d_instr", k), s_instr,
                        (tbl[k].e_pc == 32'h0) ? 32'h0 : memf(tbl[k].e_pc));
                end
            end
            redir = 1'b0;
        end

        // Response -> o_fetch_valid latency, then steady-state throughput.
        fready = 1'b1; lat = 1;
        do_reset();
        sb_en = 1'b1;
        t_rsp = -1; t_val = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_rsp && t_rsp < 0) t_rsp = cyc;
            if (s_valid && t_val < 0) t_val = cyc;
            if (t_val >= 0) break;
        end
        chk("latency", 32'(t_val - t_rsp), 32'(1 - BYP));
        c0 = consumed;
        for (int i = 0; i < 20; i++) cycle();
        chk("throughput", 32'(consumed - c0), 32'd20);

        // ID stall from reset: exactly DEPTH requests, then ordered drain.
        do_reset();
        fready = 1'b0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_req) acc++;
        end
        chk("stall_reqs", 32'(acc), 32'(DEPTH));
        chk("stall_req_off", 32'(s_req), 32'd0);
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_head", s_pc, RPC);
        fready = 1'b1;
        c0 = consumed;
        for (int i = 0; i < 16; i++) cycle();
        chk("drain_count", 32'(consumed - c0), 32'd16);

        // Latency-3 imem, redirect with responses in flight.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (pend.size() >= 2) begin found = 1'b1; break; end
        end
        chk("t3_inflight", 32'(found), 32'd1);
        redir = 1'b1; redir_pc = 32'h200;
        cycle();
        chk("t3_redir_valid", 32'(s_valid), 32'd0);
        chk("t3_redir_req", 32'(s_req), 32'd0);
        redir = 1'b0; exp_pc = 32'h200;
        wait_consume("t3_first", 32'h200);
        for (int i = 0; i < 8; i++) cycle();

        // Redirect landing on the same cycle as a response.
        lat = 1;
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 10; i++) begin
            if (pend.size() > 0 && pend[0].due <= cyc) break;
            cycle();
        end
        redir = 1'b1; redir_pc = 32'h203;
        cycle();
        chk("t4_redir_valid", 32'(s_valid), 32'd0);
        redir = 1'b0; exp_pc = 32'h200;
        cycle();
        chk("t4_req", 32'(s_req), 32'd1);
        chk("t4_addr", s_addr, 32'h200);
        wait_consume("t4_first", 32'h200);
        for (int i = 0; i < 6; i++) cycle();

        // Reset mid-flight together with a redirect: reset wins.
        lat = 3; fready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1; redir = 1'b1; redir_pc = 32'h300;
        cycle();
        chk("t5_valid", 32'(s_valid), 32'd0);
        chk("t5_pc", s_pc, 32'd0);
        redir = 1'b0;
        do_reset();
        fready = 1'b1;
        cycle();
        chk("t5_req", 32'(s_req), 32'd1);
        chk("t5_addr", s_addr, RPC);
        wait_consume("t5_first", RPC);
        for (int i = 0; i < 6; i++) cycle();

        // Address wrap past the top of the address space.
        lat = 1;
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        cycle();
        redir = 1'b0; exp_pc = 32'hFFFF_FFFC;
        wait_consume("wrap0", 32'hFFFF_FFFC);
        wait_consume("wrap1", 32'h0000_0000);
        wait_consume("wrap2", 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
